mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, meaning opcode field width.
REQ-002 SHALL have parameter ALUOP_W, default 2, meaning ALU-operation code width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM-state wait cycles (1..255).
REQ-004 SHALL have these ports, one per line:
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  instr_valid  in  1  new instruction present on opcode
  opcode  in  OPCODE_W  instruction opcode
  mem_ready  in  1  data memory completes the current access
  instr_ready  out  1  block can accept an instruction (state IDLE)
  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump  out  1 each  datapath controls
  AluOP  out  ALUOP_W  ALU operation class (00 add, 01 sub, 10 funct)
  stall  out  1  upstream fetch must hold
  instr_done  out  1  one-cycle pulse on an instruction's final cycle
  illegal  out  1  one-cycle pulse on an unknown opcode
  mem_err  out  1  one-cycle pulse on a memory timeout

Function
REQ-005 SHALL implement states IDLE, DECODE, EXEC, MEM, WB.
REQ-006 SHALL, in IDLE with instr_valid=1, latch opcode and move to DECODE; instr_valid SHALL be ignored in every other state.
REQ-007 SHALL decode opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j; all other opcodes SHALL be illegal.
REQ-008 SHALL follow these state sequences: R and addi DECODE->EXEC->WB->IDLE; lw DECODE->EXEC->MEM->WB->IDLE; sw DECODE->EXEC->MEM->IDLE; beq DECODE->EXEC->IDLE; j and illegal DECODE->IDLE.
REQ-009 SHALL stay in MEM while mem_ready=0, and leave it in the cycle after mem_ready=1 is sampled.
REQ-010 SHALL count MEM wait cycles; when the count reaches MEM_TIMEOUT with mem_ready still 0, it SHALL pulse mem_err, return to IDLE, and skip WB.
REQ-011 SHALL drive every control output to 0 in any state or opcode where that output is not asserted below. No X values SHALL be driven.
REQ-012 SHALL drive the controls combinationally from state and the latched opcode:
  RegDst=1 for R-type in EXEC and WB.
  ALUSrc=1 for lw, sw and addi in EXEC.
  MemtoReg=1 for lw in WB.
  RegWrite=1 only in WB.
  MemRead=1 for lw in MEM; MemWrite=1 for sw in MEM.
  Branch=1 for beq in EXEC; Jump=1 for j in DECODE.
  AluOP=10 for R-type, 01 for beq and 00 otherwise; it SHALL be valid in EXEC only.
REQ-013 SHALL drive instr_ready=1 only in IDLE, and stall=!instr_ready.
REQ-014 SHALL pulse instr_done in the last non-IDLE cycle of each legal instruction, but not on a timeout.
REQ-015 SHALL assert illegal in DECODE for an illegal opcode, in the same cycle, with all controls 0.
REQ-016 SHALL keep the latched opcode stable from DECODE until the state returns to IDLE, regardless of changes on the opcode input.

Reset
REQ-017 SHALL, on rst_n=0 at any time including mid-MEM, enter IDLE asynchronously and clear the latched opcode and the wait counter.
REQ-018 SHALL, during reset, drive all control and pulse outputs to 0 with instr_ready=1 and stall=0.
REQ-019 SHALL accept an instruction on the first rising clk edge after rst_n is released.

Structure
REQ-020 SHALL place the opcode constants, the AluOP encodings and the state enumeration in shared package ctrl_pkg.
REQ-021 SHALL place the combinational opcode-to-control decode in sub-module ctrl_decode, instantiated once.

Verification
REQ-022 R-type: opcode 000000 accepted at cycle 0 -> DECODE at 1, EXEC at 2 with RegDst=1 and AluOP=10, WB at 3 with RegWrite=1 and instr_done=1, instr_ready=1 at 4.
REQ-023 lw with mem_ready rising after 3 MEM cycles -> MemRead=1 for exactly 3 cycles, then WB with MemtoReg=1 and RegWrite=1.
REQ-024 sw with mem_ready held 0 and MEM_TIMEOUT=4 -> MemWrite=1 for 4 cycles, mem_err pulses once, no instr_done, back in IDLE.
REQ-025 Opcode 111111 -> illegal=1 in DECODE for 1 cycle, all controls 0, IDLE next cycle.
REQ-026 rst_n driven low during the 2nd MEM cycle of lw -> same-cycle IDLE, MemRead=0, no WB; a following beq completes with Branch=1 and AluOP=01.
REQ-027 Opcode input toggled during EXEC of addi -> ALUSrc=1 and AluOP=00 stay unchanged, and RegWrite is asserted in WB.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle instruction controller.
// Holds the state enumeration, opcode constants and ALU-operation encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_LW,
        C_SW,
        C_BEQ,
        C_ADDI,
        C_J,
        C_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam int CNT_W = 8;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode: classifies the latched opcode and derives the
// datapath controls from the current controller state.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  state_t              state,
    input  logic [OPCODE_W-1:0] opcode,
    output iclass_t             iclass,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                jump,
    output logic [ALUOP_W-1:0]  alu_op
);

    always_comb begin
        iclass = C_ILL;
        case (opcode)
            OPCODE_W'(OP_RTYPE): iclass = C_RTYPE;
            OPCODE_W'(OP_LW):    iclass = C_LW;
            OPCODE_W'(OP_SW):    iclass = C_SW;
            OPCODE_W'(OP_BEQ):   iclass = C_BEQ;
            OPCODE_W'(OP_ADDI):  iclass = C_ADDI;
            OPCODE_W'(OP_J):     iclass = C_J;
            default:             iclass = C_ILL;
        endcase
    end

    // Illegal opcodes fall through every term below, so all controls stay 0.
    always_comb begin
        reg_dst    = (iclass == C_RTYPE) && (state == S_EXEC || state == S_WB);
        alu_src    = (iclass == C_LW || iclass == C_SW || iclass == C_ADDI)
                     && (state == S_EXEC);
        mem_to_reg = (iclass == C_LW) && (state == S_WB);
        reg_write  = (state == S_WB);
        mem_read   = (iclass == C_LW) && (state == S_MEM);
        mem_write  = (iclass == C_SW) && (state == S_MEM);
        branch     = (iclass == C_BEQ) && (state == S_EXEC);
        jump       = (iclass == C_J) && (state == S_DECODE);
        alu_op     = ALUOP_W'(ALU_ADD);
        if (state == S_EXEC) begin
            if (iclass == C_RTYPE)
                alu_op = ALUOP_W'(ALU_FUNCT);
            else if (iclass == C_BEQ)
                alu_op = ALUOP_W'(ALU_SUB);
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle instruction controller: sequences IDLE/DECODE/EXEC/MEM/WB,
// bounds memory waits with a down-counter and flags illegal opcodes.
//
//   state  | meaning
//   IDLE   | ready for a new instruction, opcode latched on instr_valid
//   DECODE | latched opcode classified; j and illegal finish here
//   EXEC   | ALU operation; beq finishes here
//   MEM    | data memory access, waits on mem_ready up to MEM_TIMEOUT cycles
//   WB     | register write-back
module mc_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                instr_ready,
    output logic                RegDst,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic                Jump,
    output logic [ALUOP_W-1:0]  AluOP,
    output logic                stall,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_err
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    iclass_t             iclass;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .state      (state_q),
        .opcode     (op_q),
        .iclass     (iclass),
        .reg_dst    (RegDst),
        .alu_src    (ALUSrc),
        .mem_to_reg (MemtoReg),
        .reg_write  (RegWrite),
        .mem_read   (MemRead),
        .mem_write  (MemWrite),
        .branch     (Branch),
        .jump       (Jump),
        .alu_op     (AluOP)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && instr_valid)
                op_q <= opcode;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_done = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (iclass == C_J) begin
                    instr_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (iclass == C_ILL) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (iclass == C_LW || iclass == C_SW) begin
                    state_d = S_MEM;
                    // Terminal count 0 marks the last permitted wait cycle.
                    cnt_d   = CNT_W'(MEM_TIMEOUT - 1);
                end else if (iclass == C_BEQ) begin
                    instr_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (iclass == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (cnt_q == '0) begin
                    mem_err = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WB: begin
                instr_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal     = (state_q == S_DECODE) && (iclass == C_ILL);
    assign instr_ready = (state_q == S_IDLE);
    assign stall       = !instr_ready;

endmodule
